// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared constants and helpers for the hazard/forwarding controller:
// forwarding-select encoding, stall-counter width and a clog2 helper.
package hazard_pkg;

    localparam int STALL_CNT_W = 16;
    localparam int FWD_RF      = 0;
    localparam int FWD_STG_OFS = 1;

    function automatic int hz_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Multi-cycle write-back select sits just past the last stage select.
    function automatic int fwd_mc(input int nstg);
        return nstg + FWD_STG_OFS;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_mc_tracker.sv
// Tracks the single in-flight multi-cycle (mul/div) op: countdown, tracked rd
// and the one-cycle write-back pulse on the 1->0 count transition.
module mc_tracker
    import hazard_pkg::*;
#(
    parameter int RW     = 5,
    parameter int MC_LAT = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start_i,
    input  logic          start_wr_i,
    input  logic [RW-1:0] start_rd_i,
    output logic          busy_o,
    output logic          trk_wr_o,
    output logic [RW-1:0] trk_rd_o,
    output logic          wb_valid_o,
    output logic [RW-1:0] wb_rd_o
);

    localparam int CW = (hz_clog2(MC_LAT + 1) < 1) ? 1 : hz_clog2(MC_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] trk_rd_q, trk_rd_d;
    logic          trk_wr_q, trk_wr_d;
    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;

    always_comb begin
        cnt_d      = cnt_q;
        trk_rd_d   = trk_rd_q;
        trk_wr_d   = trk_wr_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        // wb_rd is its own register so it keeps the old rd while a new op loads.
        if (cnt_q == CW'(1) && trk_wr_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = trk_rd_q;
        end
        if (start_i) begin
            cnt_d    = CW'(MC_LAT);
            trk_wr_d = start_wr_i;
            if (start_wr_i) trk_rd_d = start_rd_i;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            trk_rd_q   <= '0;
            trk_wr_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            trk_rd_q   <= trk_rd_d;
            trk_wr_q   <= trk_wr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign busy_o     = (cnt_q != '0);
    assign trk_wr_o   = trk_wr_q;
    assign trk_rd_o   = trk_rd_q;
    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard and forwarding controller beside the ID stage: per-operand forwarding
// selects, load-use / multi-cycle stalls, stall counter. HAZ_R0_ZERO_EN makes r0 never match.
module pipe_hazard_ctl
    import hazard_pkg::*;
#(
    parameter int RW     = 5,
    parameter int NSRC   = 3,
    parameter int NSTG   = 2,
    parameter int MC_LAT = 4,
    parameter int SELW   = hz_clog2(NSTG + 2)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   id_valid,
    input  logic [NSRC*RW-1:0]     id_src,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [RW-1:0]          id_dst,
    input  logic                   id_wreg,
    input  logic                   id_mc,
    input  logic [NSTG-1:0]        st_wreg,
    input  logic [NSTG*RW-1:0]     st_rd,
    input  logic [NSTG-1:0]        st_load,
    input  logic                   flush,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall,
    output logic                   issue,
    output logic                   mc_busy,
    output logic                   mc_wb_valid,
    output logic [RW-1:0]          mc_wb_rd,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    function automatic logic reg_match(input logic [RW-1:0] a, input logic [RW-1:0] b);
`ifdef HAZ_R0_ZERO_EN
        return (a == b) && (a != '0);
`else
        return (a == b);
`endif
    endfunction

    logic          trk_wr;
    logic [RW-1:0] trk_rd;
    logic [NSRC-1:0] lu_haz, raw_haz;
    logic          waw_haz, str_haz;
    logic          unused_ld;

    // Loads beyond stage 0 forward like any other result.
    assign unused_ld = ^st_load;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [RW-1:0]   src;
        logic [NSTG-1:0] hit;
        logic            mc_hit;
        logic [SELW-1:0] sel;

        assign src = id_src[k*RW +: RW];

        for (genvar s = 0; s < NSTG; s++) begin : g_stg
            assign hit[s] = id_src_used[k] & st_wreg[s] & reg_match(src, st_rd[s*RW +: RW]);
        end

        assign mc_hit = id_src_used[k] & mc_wb_valid & reg_match(src, mc_wb_rd);

        // Youngest stage wins; walk oldest-first so lower indices overwrite.
        always_comb begin
            sel = SELW'(FWD_RF);
            if (mc_hit) sel = SELW'(fwd_mc(NSTG));
            for (int s = NSTG - 1; s >= 0; s--)
                if (hit[s]) sel = SELW'(s + FWD_STG_OFS);
        end

        assign fwd_sel[k*SELW +: SELW] = sel;
        assign lu_haz[k]  = hit[0] & st_load[0];
        assign raw_haz[k] = id_src_used[k] & mc_busy & trk_wr & reg_match(src, trk_rd);
    end

    assign waw_haz = mc_busy & trk_wr & id_wreg & reg_match(id_dst, trk_rd);
    assign str_haz = mc_busy & id_mc;

    assign stall = id_valid & ~flush & ((|lu_haz) | (|raw_haz) | waw_haz | str_haz);
    assign issue = id_valid & ~stall & ~flush;

    mc_tracker #(
        .RW     (RW),
        .MC_LAT (MC_LAT)
    ) u_mc (
        .clock      (clock),
        .resetn     (resetn),
        .start_i    (issue & id_mc),
        .start_wr_i (id_wreg),
        .start_rd_i (id_dst),
        .busy_o     (mc_busy),
        .trk_wr_o   (trk_wr),
        .trk_rd_o   (trk_rd),
        .wb_valid_o (mc_wb_valid),
        .wb_rd_o    (mc_wb_rd)
    );

    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed scoreboard bench for pipe_hazard_ctl (default parameters).
module tb_pipe_hazard_ctl;

    localparam int RW = 5, NSRC = 3, NSTG = 2, SELW = 2;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic                 id_valid;
    logic [NSRC*RW-1:0]   id_src;
    logic [NSRC-1:0]      id_src_used;
    logic [RW-1:0]        id_dst;
    logic                 id_wreg, id_mc;
    logic [NSTG-1:0]      st_wreg, st_load;
    logic [NSTG*RW-1:0]   st_rd;
    logic                 flush;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic                 stall, issue, mc_busy, mc_wb_valid;
    logic [RW-1:0]        mc_wb_rd;
    logic [15:0]          stall_cnt;

    pipe_hazard_ctl dut (
        .clock       (clock),
        .resetn      (resetn),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_dst      (id_dst),
        .id_wreg     (id_wreg),
        .id_mc       (id_mc),
        .st_wreg     (st_wreg),
        .st_rd       (st_rd),
        .st_load     (st_load),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .issue       (issue),
        .mc_busy     (mc_busy),
        .mc_wb_valid (mc_wb_valid),
        .mc_wb_rd    (mc_wb_rd),
        .stall_cnt   (stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          step;
        logic        stl, iss, bsy, wbv;
        logic [5:0]  fwd;
        logic [4:0]  wbrd;
        logic [15:0] scnt;
    } exp_t;

    exp_t        q[$];
    int          n_run = 0, n_fail = 0, n_step = 0;
    logic [15:0] sc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] srcs(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [5:0] fw(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return {c, b, a};
    endfunction

    task automatic idle();
        id_valid = 0; id_src = '0; id_src_used = '0; id_dst = '0; id_wreg = 0; id_mc = 0;
        st_wreg = '0; st_rd = '0; st_load = '0; flush = 0;
    endtask

    task automatic push_exp(input logic stl, input logic iss, input logic [5:0] fwd,
                            input logic bsy, input logic wbv, input logic [4:0] wbrd);
        exp_t e;
        e.step = n_step; e.stl = stl; e.iss = iss; e.fwd = fwd;
        e.bsy = bsy; e.wbv = wbv; e.wbrd = wbrd; e.scnt = sc;
        q.push_back(e);
        n_step++;
        if (stl && sc != 16'hFFFF) sc++;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
        idle();
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("s%0d.stall", e.step),     32'(stall),       32'(e.stl));
            chk($sformatf("s%0d.issue", e.step),     32'(issue),       32'(e.iss));
            chk($sformatf("s%0d.fwd_sel", e.step),   32'(fwd_sel),     32'(e.fwd));
            chk($sformatf("s%0d.mc_busy", e.step),   32'(mc_busy),     32'(e.bsy));
            chk($sformatf("s%0d.wb_valid", e.step),  32'(mc_wb_valid), 32'(e.wbv));
            chk($sformatf("s%0d.wb_rd", e.step),     32'(mc_wb_rd),    32'(e.wbrd));
            chk($sformatf("s%0d.stall_cnt", e.step), 32'(stall_cnt),   32'(e.scnt));
        end
    end

    initial begin
        idle(); resetn = 0; sc = '0;
        next(); push_exp(0, 0, 0, 0, 0, 0);                       // reset state
        // stage 0 beats stage 1 on rs1
        next(); resetn = 1; id_valid = 1; id_src = srcs(3, 0, 0); id_src_used = 3'b001;
        st_wreg = 2'b11; st_rd = {5'd3, 5'd3};
        push_exp(0, 1, fw(1, 0, 0), 0, 0, 0);
        // load-use on rs2, then load moves to stage 1
        next(); id_valid = 1; id_src = srcs(0, 7, 0); id_src_used = 3'b010;
        st_wreg = 2'b01; st_load = 2'b01; st_rd = {5'd0, 5'd7};
        push_exp(1, 0, fw(0, 1, 0), 0, 0, 0);
        next(); id_valid = 1; id_src = srcs(0, 7, 0); id_src_used = 3'b010;
        st_wreg = 2'b10; st_load = 2'b10; st_rd = {5'd7, 5'd0};
        push_exp(0, 1, fw(0, 2, 0), 0, 0, 0);
        // mul r5, then dependent reader
        next(); id_valid = 1; id_mc = 1; id_wreg = 1; id_dst = 5;
        push_exp(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            next(); id_valid = 1; id_src = srcs(5, 0, 0); id_src_used = 3'b001;
            push_exp(1, 0, 0, 1, 0, 0);
        end
        next(); id_valid = 1; id_src = srcs(5, 0, 0); id_src_used = 3'b001;
        push_exp(0, 1, fw(3, 0, 0), 0, 1, 5);
        // back-to-back mc ops: r9 then r10 (structural)
        next(); id_valid = 1; id_mc = 1; id_wreg = 1; id_dst = 9;
        push_exp(0, 1, 0, 0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            next(); id_valid = 1; id_mc = 1; id_wreg = 1; id_dst = 10;
            push_exp(1, 0, 0, 1, 0, 5);
        end
        next(); id_valid = 1; id_mc = 1; id_wreg = 1; id_dst = 10;
        push_exp(0, 1, 0, 0, 1, 9);
        // flush over a load-use condition
        next(); id_valid = 1; id_src = srcs(0, 7, 0); id_src_used = 3'b010;
        st_wreg = 2'b01; st_load = 2'b01; st_rd = {5'd0, 5'd7}; flush = 1;
        push_exp(0, 0, fw(0, 1, 0), 1, 0, 9);
        next(); push_exp(0, 0, 0, 1, 0, 9);
        // WAW against in-flight r10
        next(); id_valid = 1; id_wreg = 1; id_dst = 10;
        push_exp(1, 0, 0, 1, 0, 9);
        next(); push_exp(0, 0, 0, 1, 0, 9);
        next(); push_exp(0, 0, 0, 0, 1, 10);
        // mixed operands; unused operand never forwards
        next(); id_valid = 1; id_src = srcs(4, 6, 4); id_src_used = 3'b011;
        st_wreg = 2'b11; st_rd = {5'd6, 5'd4};
        push_exp(0, 1, fw(1, 2, 0), 0, 0, 10);
        // register 0 as source
        next(); id_valid = 1; id_src = srcs(0, 0, 0); id_src_used = 3'b001;
        st_wreg = 2'b01; st_rd = '0;
`ifdef HAZ_R0_ZERO_EN
        push_exp(0, 1, 0, 0, 0, 10);
`else
        push_exp(0, 1, fw(1, 0, 0), 0, 0, 10);
`endif
        next(); id_valid = 1; id_src = srcs(0, 0, 0); id_src_used = 3'b001;
        st_wreg = 2'b01; st_load = 2'b01; st_rd = '0;
`ifdef HAZ_R0_ZERO_EN
        push_exp(0, 1, 0, 0, 0, 10);
`else
        push_exp(1, 0, fw(1, 0, 0), 0, 0, 10);
`endif
        // reset aborts an in-flight mc op
        next(); id_valid = 1; id_mc = 1; id_wreg = 1; id_dst = 12;
        push_exp(0, 1, 0, 0, 0, 10);
        next(); push_exp(0, 0, 0, 1, 0, 10);
        next(); resetn = 0; sc = '0; push_exp(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            next(); resetn = 1; push_exp(0, 0, 0, 0, 0, 0);
        end
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
